// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and instruction-class flag encoding for writeback
package wb_regfile_pkg;
   localparam int DEF_DATA_W    = 64;
   localparam int DEF_NREG_LOG2 = 3;
   localparam int CLS_W    = 5;
   localparam int CLS_NOOP = 0;
   localparam int CLS_ADDI = 1;
   localparam int CLS_MOVI = 2;
   localparam int CLS_LW   = 3;
   localparam int CLS_SW   = 4;
   typedef logic [CLS_W-1:0] cls_t;
   function automatic logic cls_conflict(cls_t f);
      return (f & (f - cls_t'(1))) != '0;
   endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register array with two combinational read ports and write-before-read bypass
module regfile_2r1w #(
   parameter int DATA_W    = 64,
   parameter int NREG_LOG2 = 3,
   parameter int R0_ZERO   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [NREG_LOG2-1:0] wa,
   input  logic [DATA_W-1:0]    wd,
   input  logic [NREG_LOG2-1:0] ra_a,
   input  logic [NREG_LOG2-1:0] ra_b,
   output logic [DATA_W-1:0]    rd_a,
   output logic [DATA_W-1:0]    rd_b
);
   localparam int NREG = 2**NREG_LOG2;
   logic [DATA_W-1:0] mem [NREG];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      else if (we)
         mem[wa] <= wd;
   // hardwired zero wins over the bypass path
   assign rd_a = (R0_ZERO != 0 && ra_a == '0) ? '0 : (we && ra_a == wa) ? wd : mem[ra_a];
   assign rd_b = (R0_ZERO != 0 && ra_b == '0) ? '0 : (we && ra_b == wa) ? wd : mem[ra_b];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, register file commit, forwarding record, retire counters
module wb_regfile import wb_regfile_pkg::*; #(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NREG_LOG2 = DEF_NREG_LOG2,
   parameter int R0_ZERO   = 1,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 NOOP_WB,
   input  logic                 ADDI_WB,
   input  logic                 MOVI_WB,
   input  logic                 LW_WB,
   input  logic                 SW_WB,
   input  logic                 WRE_WB,
   input  logic [DATA_W-1:0]    D_out_WB,
   input  logic [DATA_W-1:0]    ALU_result_WB,
   input  logic [DATA_W-1:0]    Offset_WB,
   input  logic [NREG_LOG2-1:0] rt_WB,
   input  logic [NREG_LOG2-1:0] rd_addr_a,
   input  logic [NREG_LOG2-1:0] rd_addr_b,
   output logic [DATA_W-1:0]    rd_data_a,
   output logic [DATA_W-1:0]    rd_data_b,
   output logic                 fwd_valid,
   output logic [NREG_LOG2-1:0] fwd_addr,
   output logic [DATA_W-1:0]    fwd_data,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [CNT_W-1:0]     load_cnt,
   output logic                 class_err
);
   cls_t              cls;
   logic              we;
   logic [DATA_W-1:0] wd;
   always_comb begin
      cls           = '0;
      cls[CLS_NOOP] = NOOP_WB;
      cls[CLS_ADDI] = ADDI_WB;
      cls[CLS_MOVI] = MOVI_WB;
      cls[CLS_LW]   = LW_WB;
      cls[CLS_SW]   = SW_WB;
   end
   assign wd = LW_WB ? D_out_WB : MOVI_WB ? Offset_WB : ALU_result_WB;
   assign we = WRE_WB && !NOOP_WB && !SW_WB && !(R0_ZERO != 0 && rt_WB == '0);
   regfile_2r1w #(.DATA_W(DATA_W), .NREG_LOG2(NREG_LOG2), .R0_ZERO(R0_ZERO)) u_rf (
      .clk   (clk),
      .rst_n (rst),
      .we    (we),
      .wa    (rt_WB),
      .wd    (wd),
      .ra_a  (rd_addr_a),
      .ra_b  (rd_addr_b),
      .rd_a  (rd_data_a),
      .rd_b  (rd_data_b)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fwd_valid  <= 1'b0;
         fwd_addr   <= '0;
         fwd_data   <= '0;
         retire_cnt <= '0;
         load_cnt   <= '0;
         class_err  <= 1'b0;
      end else begin
         fwd_valid <= we;
         fwd_addr  <= rt_WB;
         fwd_data  <= wd;
         if (!NOOP_WB) retire_cnt <= retire_cnt + CNT_W'(1);
         if (LW_WB && !NOOP_WB) load_cnt <= load_cnt + CNT_W'(1);
         if (cls_conflict(cls)) class_err <= 1'b1;
      end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of writeback commit, bypass, forwarding, counters and reset
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst;
   logic        NOOP_WB, ADDI_WB, MOVI_WB, LW_WB, SW_WB, WRE_WB;
   logic [63:0] D_out_WB, ALU_result_WB, Offset_WB;
   logic [2:0]  rt_WB, rd_addr_a, rd_addr_b;
   logic [63:0] rd_data_a, rd_data_b, fwd_data;
   logic        fwd_valid, class_err;
   logic [2:0]  fwd_addr;
   logic [31:0] retire_cnt, load_cnt;
   logic [63:0] w_rd_a, w_rd_b, w_fwd_data;
   logic        w_fwd_valid, w_class_err;
   logic [2:0]  w_fwd_addr;
   logic [3:0]  w_retire, w_load;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   wb_regfile u_dut (
      .clk(clk), .rst(rst), .NOOP_WB(NOOP_WB), .ADDI_WB(ADDI_WB), .MOVI_WB(MOVI_WB),
      .LW_WB(LW_WB), .SW_WB(SW_WB), .WRE_WB(WRE_WB), .D_out_WB(D_out_WB),
      .ALU_result_WB(ALU_result_WB), .Offset_WB(Offset_WB), .rt_WB(rt_WB),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
      .rd_data_b(rd_data_b), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
      .fwd_data(fwd_data), .retire_cnt(retire_cnt), .load_cnt(load_cnt),
      .class_err(class_err)
   );

   wb_regfile #(.CNT_W(4)) u_wrap (
      .clk(clk), .rst(rst), .NOOP_WB(NOOP_WB), .ADDI_WB(ADDI_WB), .MOVI_WB(MOVI_WB),
      .LW_WB(LW_WB), .SW_WB(SW_WB), .WRE_WB(WRE_WB), .D_out_WB(D_out_WB),
      .ALU_result_WB(ALU_result_WB), .Offset_WB(Offset_WB), .rt_WB(rt_WB),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(w_rd_a),
      .rd_data_b(w_rd_b), .fwd_valid(w_fwd_valid), .fwd_addr(w_fwd_addr),
      .fwd_data(w_fwd_data), .retire_cnt(w_retire), .load_cnt(w_load),
      .class_err(w_class_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      {NOOP_WB, ADDI_WB, MOVI_WB, LW_WB, SW_WB, WRE_WB} = 6'b100000;
      D_out_WB = '0; ALU_result_WB = '0; Offset_WB = '0; rt_WB = '0;
   endtask

   task automatic drive(input logic [5:0] fl, input logic [2:0] rt,
                        input logic [63:0] dout, input logic [63:0] alu, input logic [63:0] off);
      @(negedge clk);
      {NOOP_WB, ADDI_WB, MOVI_WB, LW_WB, SW_WB, WRE_WB} = fl;
      rt_WB = rt; D_out_WB = dout; ALU_result_WB = alu; Offset_WB = off;
   endtask

   task automatic commit();
      @(posedge clk);
      #1 idle();
      #1;
   endtask

   // flag order: NOOP ADDI MOVI LW SW WRE
   initial begin
      rst = 1'b0;
      idle();
      rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      #12;
      chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("rst_retire", {32'd0, retire_cnt}, 64'd0);
      chk("rst_load", {32'd0, load_cnt}, 64'd0);
      chk("rst_class_err", {63'd0, class_err}, 64'd0);
      @(negedge clk) rst = 1'b1;

      drive(6'b010001, 3'd3, 64'h0, 64'hDEAD, 64'h0);
      rd_addr_a = 3'd3;
      commit();
      chk("r3_written", rd_data_a, 64'hDEAD);
      chk("r3_fwd_valid", {63'd0, fwd_valid}, 64'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_r3_clear", rd_data_a, 64'h0);
      chk("async_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("async_retire", {32'd0, retire_cnt}, 64'd0);
      chk("async_fwd_data", fwd_data, 64'h0);
      #1 rst = 1'b1;

      drive(6'b000101, 3'd5, 64'h1234, 64'hFFFF, 64'h0);
      rd_addr_a = 3'd5;
      commit();
      chk("lw_read", rd_data_a, 64'h1234);
      chk("lw_fwd_valid", {63'd0, fwd_valid}, 64'd1);
      chk("lw_fwd_addr", {61'd0, fwd_addr}, 64'd5);
      chk("lw_fwd_data", fwd_data, 64'h1234);
      chk("lw_load_cnt", {32'd0, load_cnt}, 64'd1);
      chk("lw_retire_cnt", {32'd0, retire_cnt}, 64'd1);

      drive(6'b001001, 3'd2, 64'h0, 64'h0, 64'h7);
      rd_addr_a = 3'd2; rd_addr_b = 3'd2;
      #1;
      chk("bypass_b", rd_data_b, 64'h7);
      chk("bypass_a_same", rd_data_a, 64'h7);
      commit();
      chk("movi_stored", rd_data_b, 64'h7);

      drive(6'b010001, 3'd0, 64'h0, 64'h55, 64'h0);
      rd_addr_a = 3'd0;
      #1 chk("r0_no_bypass", rd_data_a, 64'h0);
      commit();
      chk("r0_read", rd_data_a, 64'h0);
      chk("r0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("r0_retire", {32'd0, retire_cnt}, 64'd3);

      drive(6'b001001, 3'd7, 64'h0, 64'h0, 64'h42);
      commit();
      chk("movi_r7_fwd", {63'd0, fwd_valid}, 64'd1);
      drive(6'b000011, 3'd4, 64'h0, 64'h9, 64'h0);
      rd_addr_a = 3'd4;
      #1 chk("sw_no_bypass", rd_data_a, 64'h0);
      commit();
      chk("sw_r4", rd_data_a, 64'h0);
      chk("sw_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("sw_retire", {32'd0, retire_cnt}, 64'd5);

      drive(6'b001001, 3'd6, 64'h0, 64'h0, 64'h11);
      commit();
      drive(6'b100001, 3'd6, 64'h0, 64'h77, 64'h0);
      rd_addr_a = 3'd6;
      commit();
      chk("noop_r6", rd_data_a, 64'h11);
      chk("noop_retire", {32'd0, retire_cnt}, 64'd6);
      chk("noop_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      chk("pre_class_err", {63'd0, class_err}, 64'd0);

      drive(6'b010101, 3'd1, 64'hA, 64'hB, 64'h0);
      rd_addr_a = 3'd1;
      commit();
      chk("cls_r1", rd_data_a, 64'hA);
      chk("cls_err_set", {63'd0, class_err}, 64'd1);
      chk("cls_load_cnt", {32'd0, load_cnt}, 64'd2);
      drive(6'b001001, 3'd2, 64'h0, 64'h0, 64'h3);
      commit();
      chk("cls_err_sticky", {63'd0, class_err}, 64'd1);

      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst2_class_err", {63'd0, class_err}, 64'd0);
      chk("rst2_wrap_retire", {60'd0, w_retire}, 64'd0);
      #1 rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive(6'b010000, 3'd1, 64'h0, 64'h1, 64'h0);
         commit();
      end
      chk("wrap_pre", {60'd0, w_retire}, 64'd15);
      for (int i = 0; i < 2; i++) begin
         drive(6'b010000, 3'd1, 64'h0, 64'h1, 64'h0);
         commit();
      end
      chk("wrap_post", {60'd0, w_retire}, 64'd1);
      chk("wide_no_wrap", {32'd0, retire_cnt}, 64'd17);
      chk("wrap_load", {60'd0, w_load}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file. Sits directly after the M/WB pipeline register.
- Selects the writeback value per instruction class and commits it to an 8-entry x 64-bit register file.
- Serves two decode-stage read ports with same-cycle write bypass.
- Publishes a registered writeback record for EX-stage forwarding, plus retire/load counters and a sticky decode-error flag.

Parameters:
- DATA_W, 64, register and data-path width
- NREG_LOG2, 3, register address width (2**NREG_LOG2 registers)
- R0_ZERO, 1, when 1 register 0 reads as zero and ignores writes
- CNT_W, 32, width of retire and load counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- NOOP_WB  in  1  WB instruction is a no-op
- ADDI_WB  in  1  WB instruction is ADDI
- MOVI_WB  in  1  WB instruction is MOVI
- LW_WB  in  1  WB instruction is a load
- SW_WB  in  1  WB instruction is a store
- WRE_WB  in  1  register write enable from decode
- D_out_WB  in  DATA_W  data-memory read data
- ALU_result_WB  in  DATA_W  ALU result
- Offset_WB  in  DATA_W  sign-extended immediate
- rt_WB  in  NREG_LOG2  destination register
- rd_addr_a  in  NREG_LOG2  read port A address (ID stage)
- rd_addr_b  in  NREG_LOG2  read port B address (ID stage)
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- fwd_valid  out  1  registered: a write committed last cycle
- fwd_addr  out  NREG_LOG2  registered: destination of that write
- fwd_data  out  DATA_W  registered: value of that write
- retire_cnt  out  CNT_W  count of retired non-NOOP instructions
- load_cnt  out  CNT_W  count of retired loads
- class_err  out  1  sticky: more than one class flag asserted in a cycle

Behaviour:
- Reset (rst=0, async):
  - All registers cleared to 0.
  - fwd_valid=0, fwd_addr=0, fwd_data=0.
  - retire_cnt=0, load_cnt=0, class_err=0.
  - Reset overrides any write in flight; the cycle after release behaves normally.
- Write-data select, priority order:
  - LW_WB -> D_out_WB
  - else MOVI_WB -> Offset_WB
  - else ALU_result_WB (covers ADDI and R-type)
- Commit enable: we = WRE_WB & ~NOOP_WB & ~SW_WB & ~(R0_ZERO & rt_WB==0).
- Commit timing: a write lands on the rising edge of the cycle in which the WB inputs are presented. Latency is 1 clk.
- Reads are combinational from the array.
  - Bypass: if we=1 and rd_addr_x==rt_WB, rd_data_x returns the write data in the same cycle (write-before-read).
  - If R0_ZERO=1 and rd_addr_x==0, rd_data_x=0, overriding bypass.
- Forwarding record: fwd_valid, fwd_addr, fwd_data are loaded every clk with we, rt_WB and the write data. fwd_valid falls to 0 the cycle after any non-committing instruction.
- Counters:
  - retire_cnt increments when ~NOOP_WB.
  - load_cnt increments when LW_WB & ~NOOP_WB.
  - Both wrap modulo 2**CNT_W with no saturation.
- Class check: class_err is set on the clk after any cycle where more than one of {ADDI, MOVI, LW, SW} is high, or NOOP is high together with any other flag. It remains 1 until reset. Data selection still follows the priority order.
- Simultaneous events:
  - Same-cycle write and read to the same address: bypass applies.
  - Both read ports on the same address: both return identical data.

Decomposition:
- Shared package holds:
  - DATA_W and NREG_LOG2 defaults
  - class-flag bit positions {NOOP, ADDI, MOVI, LW, SW} as a 5-bit vector encoding, reused by the M/WB register and decode
- One natural sub-module: regfile_2r1w. It holds the 8x64 array, two combinational read ports, one synchronous write port, and internal bypass.
- Writeback select, forwarding record, counters and error flag live in wb_regfile.

Test Plan:
- Reset mid-run: write 0xDEAD to r3, then pulse rst low mid-cycle -> r3 reads 0 immediately after the async clear; fwd_valid=0; counters=0.
- Load writeback: LW_WB=1, WRE=1, rt=5, D_out=0x1234, ALU_result=0xFFFF -> next cycle rd_addr_a=5 returns 0x1234; fwd_valid=1, fwd_addr=5, fwd_data=0x1234; load_cnt=1, retire_cnt=1.
- Bypass: MOVI_WB=1, WRE=1, rt=2, Offset=0x7 with rd_addr_b=2 in the same cycle -> rd_data_b=0x7 combinationally before the edge.
- R0 protection: ADDI_WB=1, WRE=1, rt=0, ALU_result=0x55 -> rd_data_a(addr 0)=0; fwd_valid=0; retire_cnt increments.
- Store and no-op: SW_WB=1, WRE=1, rt=4, ALU_result=0x9 -> r4 unchanged, retire_cnt+1; then NOOP_WB=1 -> no counter change, fwd_valid=0.
- Class error and wrap: LW_WB=ADDI_WB=1, rt=1, D_out=0xA -> r1=0xA and class_err=1 sticky. Separately, preload retire_cnt near 2**CNT_W-1 (CNT_W=4 build), retire 2 -> wraps to 0x1.
